// File: rtl/matrix_loader_if.sv
// Host-to-loader row stream: one packed matrix row per accepted word.
// The master drives valid/data and the loader (slave) answers with ready.
interface matrix_loader_if #(
  parameter int DW = 64
);
  logic          S_VALID;
  logic          S_READY;
  logic [DW-1:0] S_DATA;

  modport master (output S_VALID, output S_DATA, input S_READY);
  modport slave  (input S_VALID, input S_DATA, output S_READY);
endinterface

// File: rtl/matrix_loader.sv
// Streams M input rows then N weight rows from the host into two SRAMs,
// then launches the MAC array and waits for its completion pulse.
module matrix_loader #(
  parameter int DW = 64,
  parameter int AW = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CFG_VALID,
  input  logic [11:0]    CFG_MNT,
  matrix_loader_if.slave s_if,
  output logic           EN_I,
  output logic [AW-1:0]  ADDR_I,
  output logic [DW-1:0]  WDATA_I,
  output logic           EN_W,
  output logic [AW-1:0]  ADDR_W,
  output logic [DW-1:0]  WDATA_W,
  output logic [11:0]    MNT,
  output logic           START,
  input  logic           DONE,
  output logic           BUSY,
  output logic           ERR
);

  // Counters carry one extra bit so a full count of 8 never aliases address 0.
  localparam int CW = AW + 1;
  localparam int XW = (CW > 4) ? CW : 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_I = 3'd1,
    ST_LOAD_W = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_LAUNCH = 3'd4,
    ST_WAIT   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [CW-1:0] r_cnt_i;
  logic [CW-1:0] r_cnt_w;
  logic [11:0]   r_mnt;
  logic          r_err;
  logic          r_s_ready;
  logic          r_en_i;
  logic          r_en_w;
  logic [AW-1:0] r_addr_i;
  logic [AW-1:0] r_addr_w;
  logic [DW-1:0] r_wdata_i;
  logic [DW-1:0] r_wdata_w;
  logic          r_start;
  logic          r_busy;

  logic          w_cfg_ok;
  logic          w_accept;
  logic          w_last_i;
  logic          w_last_w;
  logic          w_s_ready_d;
  logic          w_en_i_d;
  logic          w_en_w_d;
  logic          w_start_d;
  logic          w_busy_d;

  function automatic logic dim_ok(input logic [3:0] d);
    return (d != 4'd0) && (d <= 4'd8);
  endfunction

  assign w_cfg_ok = dim_ok(CFG_MNT[11:8]) && dim_ok(CFG_MNT[7:4]) && dim_ok(CFG_MNT[3:0]);
  assign w_accept = s_if.S_VALID && r_s_ready;
  assign w_last_i = ((XW'(r_cnt_i) + XW'(1'b1)) == XW'(r_mnt[11:8]));
  assign w_last_w = ((XW'(r_cnt_w) + XW'(1'b1)) == XW'(r_mnt[7:4]));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (CFG_VALID && w_cfg_ok) begin
          w_next_state = ST_LOAD_I;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD_I: begin
        if (w_accept && w_last_i) begin
          w_next_state = ST_LOAD_W;
        end else begin
          w_next_state = ST_LOAD_I;
        end
      end
      ST_LOAD_W: begin
        if (w_accept && w_last_w) begin
          w_next_state = ST_FLUSH;
        end else begin
          w_next_state = ST_LOAD_W;
        end
      end
      ST_FLUSH:  w_next_state = ST_LAUNCH;
      ST_LAUNCH: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (DONE) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output decode; flags derive from the upcoming state so they can be registered.
  always_comb begin
    w_s_ready_d = (w_next_state == ST_LOAD_I) || (w_next_state == ST_LOAD_W);
    w_busy_d    = (w_next_state != ST_IDLE);
    w_start_d   = (w_next_state == ST_LAUNCH);
    w_en_i_d    = (r_state == ST_LOAD_I) && w_accept;
    w_en_w_d    = (r_state == ST_LOAD_W) && w_accept;
  end

  // Registered control outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
    end else begin
      r_s_ready <= w_s_ready_d;
      r_busy    <= w_busy_d;
      r_start   <= w_start_d;
    end
  end

  // Configuration latch, sticky error flag and row counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mnt   <= 12'h000;
      r_err   <= 1'b0;
      r_cnt_i <= '0;
      r_cnt_w <= '0;
    end else if ((r_state == ST_IDLE) && CFG_VALID) begin
      if (w_cfg_ok) begin
        r_mnt   <= CFG_MNT;
        r_err   <= 1'b0;
        r_cnt_i <= '0;
        r_cnt_w <= '0;
      end else begin
        r_err   <= 1'b1;
      end
    end else if (w_en_i_d) begin
      r_cnt_i <= r_cnt_i + CW'(1'b1);
    end else if (w_en_w_d) begin
      r_cnt_w <= r_cnt_w + CW'(1'b1);
    end else begin
      r_cnt_i <= r_cnt_i;
    end
  end

  // SRAM write ports, one cycle behind the accepting edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_en_i    <= 1'b0;
      r_en_w    <= 1'b0;
      r_addr_i  <= '0;
      r_addr_w  <= '0;
      r_wdata_i <= '0;
      r_wdata_w <= '0;
    end else begin
      r_en_i <= w_en_i_d;
      r_en_w <= w_en_w_d;
      if (w_en_i_d) begin
        r_addr_i  <= r_cnt_i[AW-1:0];
        r_wdata_i <= s_if.S_DATA;
      end else begin
        r_addr_i  <= r_addr_i;
      end
      if (w_en_w_d) begin
        r_addr_w  <= r_cnt_w[AW-1:0];
        r_wdata_w <= s_if.S_DATA;
      end else begin
        r_addr_w  <= r_addr_w;
      end
    end
  end

  assign s_if.S_READY = r_s_ready;
  assign EN_I         = r_en_i;
  assign ADDR_I       = r_addr_i;
  assign WDATA_I      = r_wdata_i;
  assign EN_W         = r_en_w;
  assign ADDR_W       = r_addr_w;
  assign WDATA_W      = r_wdata_w;
  assign MNT          = r_mnt;
  assign START        = r_start;
  assign BUSY         = r_busy;
  assign ERR          = r_err;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed + randomized bench for matrix_loader: random row data and configs,
// expected SRAM write lists built from the row-streaming rules.
module tb_matrix_loader;

  localparam int DW = 64;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          CFG_VALID = 1'b0;
  logic [11:0]   CFG_MNT = 12'h000;
  logic          EN_I, EN_W, START, BUSY, ERR;
  logic [AW-1:0] ADDR_I, ADDR_W;
  logic [DW-1:0] WDATA_I, WDATA_W;
  logic [11:0]   MNT;
  logic          DONE = 1'b0;

  matrix_loader_if #(.DW(DW)) ml_if ();

  matrix_loader #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .CFG_VALID(CFG_VALID), .CFG_MNT(CFG_MNT),
    .s_if(ml_if),
    .EN_I(EN_I), .ADDR_I(ADDR_I), .WDATA_I(WDATA_I),
    .EN_W(EN_W), .ADDR_W(ADDR_W), .WDATA_W(WDATA_W),
    .MNT(MNT), .START(START), .DONE(DONE), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Write/pulse log gathered on the falling edge.
  logic [AW-1:0] obs_i_addr[$];
  logic [DW-1:0] obs_i_data[$];
  logic [AW-1:0] obs_w_addr[$];
  logic [DW-1:0] obs_w_data[$];
  int            n_start   = 0;
  int            n_overlap = 0;
  int            n_mnt_bad = 0;
  logic [11:0]   exp_mnt   = 12'h000;
  logic [11:0]   last_mnt  = 12'h000;

  always @(negedge CLK) begin
    if (EN_I) begin obs_i_addr.push_back(ADDR_I); obs_i_data.push_back(WDATA_I); end
    if (EN_W) begin obs_w_addr.push_back(ADDR_W); obs_w_data.push_back(WDATA_W); end
    if (EN_I && EN_W) n_overlap++;
    if (START) n_start++;
    if (BUSY && (MNT !== exp_mnt)) n_mnt_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word and hold it until accepted; returns at posedge+1 after acceptance.
  task automatic send_word(input logic [63:0] d);
    int waited = 0;
    ml_if.S_VALID = 1'b1;
    ml_if.S_DATA  = d;
    @(negedge CLK);
    while (!ml_if.S_READY && waited < 20) begin
      waited++;
      @(negedge CLK);
    end
    chk("s_ready_during_load", ml_if.S_READY, 64'd1);
    @(posedge CLK); #1;
  endtask

  task automatic run_txn(input logic [11:0] cfg, input int gap_mode, input bit inject);
    logic [63:0] exp_i[$];
    logic [63:0] exp_w[$];
    logic [63:0] d;
    int m, n, bi, bw, bs, bo, bm;
    m  = int'(cfg[11:8]);
    n  = int'(cfg[7:4]);
    bi = obs_i_addr.size(); bw = obs_w_addr.size();
    bs = n_start; bo = n_overlap; bm = n_mnt_bad;
    @(posedge CLK); #1;
    exp_mnt = cfg; CFG_VALID = 1'b1; CFG_MNT = cfg;
    @(posedge CLK); #1;
    CFG_VALID = 1'b0;
    @(negedge CLK);
    chk("cfg_busy", BUSY, 64'd1);
    chk("cfg_ready", ml_if.S_READY, 64'd1);
    chk("cfg_mnt", MNT, 64'(cfg));
    chk("cfg_err_clear", ERR, 64'd0);
    @(posedge CLK); #1;
    for (int k = 0; k < m + n; k++) begin
      d = {$urandom, $urandom};
      if (k < m) exp_i.push_back(d); else exp_w.push_back(d);
      if (inject && k == m) begin
        CFG_VALID = 1'b1; CFG_MNT = 12'h222; DONE = 1'b1;
      end
      send_word(d);
      CFG_VALID = 1'b0; DONE = 1'b0;
      if (k != m + n - 1 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
        ml_if.S_VALID = 1'b0;
        @(posedge CLK); #1;
      end
    end
    ml_if.S_VALID = 1'b0;
    @(negedge CLK);
    chk("flush_start_low", START, 64'd0);
    chk("flush_last_weight_write", EN_W, 64'd1);
    @(negedge CLK);
    chk("launch_start", START, 64'd1);
    @(negedge CLK);
    chk("wait_start_low", START, 64'd0);
    chk("wait_busy", BUSY, 64'd1);
    chk("wait_ready_low", ml_if.S_READY, 64'd0);
    repeat ($urandom_range(0, 3)) @(negedge CLK);
    @(posedge CLK); #1;
    DONE = 1'b1;
    @(negedge CLK);
    chk("done_cycle_busy", BUSY, 64'd1);
    @(posedge CLK); #1;
    DONE = 1'b0;
    @(negedge CLK);
    chk("after_done_busy", BUSY, 64'd0);
    chk("after_done_mnt", MNT, 64'(cfg));
    chk("i_write_count", 64'(obs_i_addr.size() - bi), 64'(m));
    for (int j = 0; j < m && (bi + j) < obs_i_addr.size(); j++) begin
      chk("i_addr", obs_i_addr[bi + j], 64'(j));
      chk("i_data", obs_i_data[bi + j], exp_i[j]);
    end
    chk("w_write_count", 64'(obs_w_addr.size() - bw), 64'(n));
    for (int j = 0; j < n && (bw + j) < obs_w_addr.size(); j++) begin
      chk("w_addr", obs_w_addr[bw + j], 64'(j));
      chk("w_data", obs_w_data[bw + j], exp_w[j]);
    end
    chk("start_pulses", 64'(n_start - bs), 64'd1);
    chk("en_overlap", 64'(n_overlap - bo), 64'd0);
    chk("mnt_stable", 64'(n_mnt_bad - bm), 64'd0);
    last_mnt = cfg;
  endtask

  task automatic bad_cfg(input logic [11:0] cfg);
    @(posedge CLK); #1;
    CFG_VALID = 1'b1; CFG_MNT = cfg;
    @(posedge CLK); #1;
    CFG_VALID = 1'b0;
    @(negedge CLK);
    chk("bad_err", ERR, 64'd1);
    chk("bad_busy", BUSY, 64'd0);
    chk("bad_ready", ml_if.S_READY, 64'd0);
    chk("bad_mnt_kept", MNT, 64'(last_mnt));
    @(negedge CLK);
    chk("bad_ready_later", ml_if.S_READY, 64'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, ml_if.S_READY, 64'd0);
    chk({tag, "_en_i"}, EN_I, 64'd0);
    chk({tag, "_en_w"}, EN_W, 64'd0);
    chk({tag, "_addr_i"}, ADDR_I, 64'd0);
    chk({tag, "_addr_w"}, ADDR_W, 64'd0);
    chk({tag, "_wdata_i"}, WDATA_I, 64'd0);
    chk({tag, "_wdata_w"}, WDATA_W, 64'd0);
    chk({tag, "_mnt"}, MNT, 64'd0);
    chk({tag, "_start"}, START, 64'd0);
    chk({tag, "_busy"}, BUSY, 64'd0);
    chk({tag, "_err"}, ERR, 64'd0);
  endtask

  initial begin
    logic [3:0] rm, rn, rt;
    int bi;
    ml_if.S_VALID = 1'b0;
    ml_if.S_DATA  = '0;
    repeat (3) @(negedge CLK);
    chk_reset_values("reset");
    @(posedge CLK); #1;
    RST = 1'b0;

    run_txn(12'h443, 0, 1'b0);
    run_txn(12'h888, 1, 1'b0);
    bad_cfg(12'h093);
    run_txn(12'h443, 0, 1'b1);
    bad_cfg(12'h993);
    bad_cfg(12'h880);
    run_txn(12'h181, 2, 1'b0);

    // Abort after two accepted input rows.
    @(posedge CLK); #1;
    exp_mnt = 12'h443; CFG_VALID = 1'b1; CFG_MNT = 12'h443;
    @(posedge CLK); #1;
    CFG_VALID = 1'b0;
    send_word({$urandom, $urandom});
    send_word({$urandom, $urandom});
    RST = 1'b1;
    ml_if.S_VALID = 1'b0;
    #1;
    chk_reset_values("midload_reset");
    bi = obs_i_addr.size();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    last_mnt = 12'h000;
    repeat (2) @(negedge CLK);
    chk("no_write_after_abort", 64'(obs_i_addr.size()), 64'(bi));
    chk("idle_after_abort", BUSY, 64'd0);
    run_txn(12'h443, 0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      rm = 4'($urandom_range(1, 8));
      rn = 4'($urandom_range(1, 8));
      rt = 4'($urandom_range(1, 8));
      run_txn({rm, rn, rt}, 2, r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
